// File: rtl/sdc_regs_pkg.sv
// Shared definitions for the sdc_controller init sequencer: register map
// offsets of the sdc_controller slave, default timeout value and the
// sequencer state encoding.
package sdc_regs_pkg;

   localparam logic [7:0] SDC_ARGUMENT          = 8'h00;
   localparam logic [7:0] SDC_COMMAND           = 8'h04;
   localparam logic [7:0] SDC_RESP0             = 8'h08;
   localparam logic [7:0] SDC_RESP1             = 8'h0C;
   localparam logic [7:0] SDC_RESP2             = 8'h10;
   localparam logic [7:0] SDC_RESP3             = 8'h14;
   localparam logic [7:0] SDC_DATA_TIMEOUT      = 8'h18;
   localparam logic [7:0] SDC_CONTROL           = 8'h1C;
   localparam logic [7:0] SDC_CMD_TIMEOUT       = 8'h20;
   localparam logic [7:0] SDC_CLOCK_DIVIDER     = 8'h24;
   localparam logic [7:0] SDC_SOFTWARE_RESET    = 8'h28;
   localparam logic [7:0] SDC_POWER_CONTROL     = 8'h2C;
   localparam logic [7:0] SDC_CAPABILITY        = 8'h30;
   localparam logic [7:0] SDC_CMD_EVENT_STATUS  = 8'h34;
   localparam logic [7:0] SDC_CMD_EVENT_ENABLE  = 8'h38;
   localparam logic [7:0] SDC_DATA_EVENT_STATUS = 8'h3C;
   localparam logic [7:0] SDC_DATA_EVENT_ENABLE = 8'h40;
   localparam logic [7:0] SDC_BLOCK_SIZE        = 8'h44;
   localparam logic [7:0] SDC_BLOCK_COUNT       = 8'h48;
   localparam logic [7:0] SDC_DATA_XFER_ADDRESS = 8'h60;

   // Default value the controller's timeout registers are usually loaded with.
   localparam logic [23:0] SDC_DEFAULT_TIMEOUT = 24'h7FFF;

   typedef enum logic [2:0] {
      SEQ_IDLE,
      SEQ_WR_REQ,
      SEQ_WR_WAIT,
      SEQ_RD_REQ,
      SEQ_RD_WAIT,
      SEQ_GAP,
      SEQ_DONE,
      SEQ_FAIL
   } seq_state_e;

endpackage

// File: rtl/sdc_wb_xfer.sv
// One Wishbone classic transaction at a time. A req pulse registers the
// bus signals; cyc/stb stay up until ack is seen or the ack timeout expires.
// ack_done/timeout are combinational so the caller reacts on the same edge
// that drops cyc.
module sdc_wb_xfer
   import sdc_regs_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 32,
   parameter int ACK_TIMEOUT = 255
) (
   input  logic              wb_clk,
   input  logic              reset,
   input  logic              req,
   input  logic              we,
   input  logic [ADDR_W-1:0] adr,
   input  logic [DATA_W-1:0] dat,
   input  logic [3:0]        sel,
   output logic              ack_done,
   output logic              timeout,
   output logic [DATA_W-1:0] rdata,
   output logic [ADDR_W-1:0] wbm_adr_o,
   output logic [DATA_W-1:0] wbm_dat_o,
   input  logic [DATA_W-1:0] wbm_dat_i,
   output logic [3:0]        wbm_sel_o,
   output logic              wbm_we_o,
   output logic              wbm_cyc_o,
   output logic              wbm_stb_o,
   input  logic              wbm_ack_i
);

   localparam logic [15:0] TMO_LOAD = 16'(ACK_TIMEOUT);

   logic [15:0] cnt_reg;

   // Ack has priority over the last timeout cycle.
   assign ack_done = wbm_cyc_o & wbm_ack_i;
   assign timeout  = wbm_cyc_o & ~wbm_ack_i & (cnt_reg == 16'd1);
   assign rdata    = wbm_dat_i;

   // Bus request registers and ack countdown; reset drops cyc/stb at once.
   always_ff @(posedge wb_clk or posedge reset) begin
      if (reset) begin
         wbm_adr_o <= '0;
         wbm_dat_o <= '0;
         wbm_sel_o <= '0;
         wbm_we_o  <= 1'b0;
         wbm_cyc_o <= 1'b0;
         wbm_stb_o <= 1'b0;
         cnt_reg   <= '0;
      end else if (req && !wbm_cyc_o) begin
         wbm_adr_o <= adr;
         wbm_dat_o <= dat;
         wbm_sel_o <= sel;
         wbm_we_o  <= we;
         wbm_cyc_o <= 1'b1;
         wbm_stb_o <= 1'b1;
         cnt_reg   <= TMO_LOAD;
      end else if (ack_done || timeout) begin
         wbm_we_o  <= 1'b0;
         wbm_cyc_o <= 1'b0;
         wbm_stb_o <= 1'b0;
         cnt_reg   <= '0;
      end else if (wbm_cyc_o) begin
         cnt_reg   <= cnt_reg - 16'd1;
      end
   end

endmodule

// File: rtl/sdc_wb_init_sequencer.sv
// Programs a table of sdc_controller registers over Wishbone after reset or
// on a start pulse, optionally reading each masked entry back to verify it.
// A start pulse is first latched into the pending flag (which reset preloads
// from AUTO_START) and accepted on the following edge.
module sdc_wb_init_sequencer
   import sdc_regs_pkg::*;
#(
   parameter int ADDR_W      = 8,
   parameter int DATA_W      = 32,
   parameter int NUM_REGS    = 11,
   parameter int IDX_W       = 6,
   parameter int ACK_TIMEOUT = 255,
   parameter int VERIFY_EN   = 1,
   parameter int AUTO_START  = 1
) (
   input  logic                       wb_clk,
   input  logic                       reset,
   input  logic                       start,
   input  logic [NUM_REGS*ADDR_W-1:0] cfg_addr,
   input  logic [NUM_REGS*DATA_W-1:0] cfg_data,
   input  logic [NUM_REGS*4-1:0]      cfg_sel,
   input  logic [NUM_REGS*DATA_W-1:0] cfg_vmask,
   output logic [ADDR_W-1:0]          wbm_adr_o,
   output logic [DATA_W-1:0]          wbm_dat_o,
   input  logic [DATA_W-1:0]          wbm_dat_i,
   output logic [3:0]                 wbm_sel_o,
   output logic                       wbm_we_o,
   output logic                       wbm_cyc_o,
   output logic                       wbm_stb_o,
   input  logic                       wbm_ack_i,
   output logic                       busy,
   output logic                       done,
   output logic                       fail,
   output logic                       fail_timeout,
   output logic [IDX_W-1:0]           fail_idx,
   output logic [DATA_W-1:0]          fail_rdata
);

   localparam int               TBL_N    = 1 << IDX_W;
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_REGS - 1);
   localparam logic [IDX_W-1:0] IDX_ONE  = IDX_W'(1);

   seq_state_e        state_reg;
   logic [IDX_W-1:0]  idx_reg;
   logic              rd_phase_reg;
   logic              pending_reg;

   // Flat cfg buses unpacked into index-addressable tables, padded to the
   // full index range so any idx value selects a defined entry.
   logic [ADDR_W-1:0] addr_tbl  [TBL_N];
   logic [DATA_W-1:0] data_tbl  [TBL_N];
   logic [3:0]        sel_tbl   [TBL_N];
   logic [DATA_W-1:0] vmask_tbl [TBL_N];

   genvar gi;
   generate
      for (gi = 0; gi < TBL_N; gi++) begin : g_tbl
         if (gi < NUM_REGS) begin : g_used
            assign addr_tbl[gi]  = cfg_addr[gi*ADDR_W +: ADDR_W];
            assign data_tbl[gi]  = cfg_data[gi*DATA_W +: DATA_W];
            assign sel_tbl[gi]   = cfg_sel[gi*4 +: 4];
            assign vmask_tbl[gi] = cfg_vmask[gi*DATA_W +: DATA_W];
         end else begin : g_pad
            assign addr_tbl[gi]  = '0;
            assign data_tbl[gi]  = '0;
            assign sel_tbl[gi]   = '0;
            assign vmask_tbl[gi] = '0;
         end
      end
   endgenerate

   logic [ADDR_W-1:0] cur_addr;
   logic [DATA_W-1:0] cur_data;
   logic [3:0]        cur_sel;
   logic [DATA_W-1:0] cur_vmask;
   logic              xfer_req;
   logic              xfer_we;
   logic              xfer_ack;
   logic              xfer_timeout;
   logic [DATA_W-1:0] xfer_rdata;
   logic              mismatch;

   assign cur_addr  = addr_tbl[idx_reg];
   assign cur_data  = data_tbl[idx_reg];
   assign cur_sel   = sel_tbl[idx_reg];
   assign cur_vmask = vmask_tbl[idx_reg];

   // Reads are only issued for entries with a non-zero verify mask.
   assign xfer_req  = (state_reg == SEQ_WR_REQ) ||
                      ((state_reg == SEQ_RD_REQ) && (cur_vmask != '0));
   assign xfer_we   = (state_reg == SEQ_WR_REQ);
   assign mismatch  = |((xfer_rdata ^ cur_data) & cur_vmask);

   sdc_wb_xfer #(
      .ADDR_W      (ADDR_W),
      .DATA_W      (DATA_W),
      .ACK_TIMEOUT (ACK_TIMEOUT)
   ) u_xfer (
      .wb_clk    (wb_clk),
      .reset     (reset),
      .req       (xfer_req),
      .we        (xfer_we),
      .adr       (cur_addr),
      .dat       (cur_data),
      .sel       (cur_sel),
      .ack_done  (xfer_ack),
      .timeout   (xfer_timeout),
      .rdata     (xfer_rdata),
      .wbm_adr_o (wbm_adr_o),
      .wbm_dat_o (wbm_dat_o),
      .wbm_dat_i (wbm_dat_i),
      .wbm_sel_o (wbm_sel_o),
      .wbm_we_o  (wbm_we_o),
      .wbm_cyc_o (wbm_cyc_o),
      .wbm_stb_o (wbm_stb_o),
      .wbm_ack_i (wbm_ack_i)
   );

   // Sequencer FSM with registered status outputs.
   always_ff @(posedge wb_clk or posedge reset) begin
      if (reset) begin
         state_reg    <= SEQ_IDLE;
         idx_reg      <= '0;
         rd_phase_reg <= 1'b0;
         pending_reg  <= (AUTO_START != 0);
         busy         <= 1'b0;
         done         <= 1'b0;
         fail         <= 1'b0;
         fail_timeout <= 1'b0;
         fail_idx     <= '0;
         fail_rdata   <= '0;
      end else begin
         case (state_reg)
            SEQ_IDLE, SEQ_DONE, SEQ_FAIL: begin
               if (pending_reg) begin
                  pending_reg  <= 1'b0;
                  idx_reg      <= '0;
                  rd_phase_reg <= 1'b0;
                  busy         <= 1'b1;
                  done         <= 1'b0;
                  fail         <= 1'b0;
                  fail_timeout <= 1'b0;
                  fail_idx     <= '0;
                  fail_rdata   <= '0;
                  state_reg    <= SEQ_WR_REQ;
               end else if (start) begin
                  pending_reg  <= 1'b1;
               end
            end
            SEQ_WR_REQ: state_reg <= SEQ_WR_WAIT;
            SEQ_WR_WAIT: begin
               if (xfer_ack) begin
                  state_reg <= SEQ_GAP;
               end else if (xfer_timeout) begin
                  state_reg    <= SEQ_FAIL;
                  fail         <= 1'b1;
                  busy         <= 1'b0;
                  fail_timeout <= 1'b1;
                  fail_idx     <= idx_reg;
               end
            end
            SEQ_RD_REQ: begin
               if (cur_vmask != '0) begin
                  state_reg <= SEQ_RD_WAIT;
               end else if (idx_reg != LAST_IDX) begin
                  idx_reg   <= idx_reg + IDX_ONE;
               end else begin
                  state_reg <= SEQ_DONE;
                  done      <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            SEQ_RD_WAIT: begin
               if (xfer_ack && mismatch) begin
                  state_reg    <= SEQ_FAIL;
                  fail         <= 1'b1;
                  busy         <= 1'b0;
                  fail_timeout <= 1'b0;
                  fail_idx     <= idx_reg;
                  fail_rdata   <= xfer_rdata;
               end else if (xfer_ack) begin
                  state_reg    <= SEQ_GAP;
               end else if (xfer_timeout) begin
                  state_reg    <= SEQ_FAIL;
                  fail         <= 1'b1;
                  busy         <= 1'b0;
                  fail_timeout <= 1'b1;
                  fail_idx     <= idx_reg;
               end
            end
            SEQ_GAP: begin
               if (idx_reg != LAST_IDX) begin
                  idx_reg   <= idx_reg + IDX_ONE;
                  state_reg <= rd_phase_reg ? SEQ_RD_REQ : SEQ_WR_REQ;
               end else if (!rd_phase_reg && (VERIFY_EN != 0)) begin
                  idx_reg      <= '0;
                  rd_phase_reg <= 1'b1;
                  state_reg    <= SEQ_RD_REQ;
               end else begin
                  state_reg <= SEQ_DONE;
                  done      <= 1'b1;
                  busy      <= 1'b0;
               end
            end
            default: state_reg <= SEQ_IDLE;
         endcase
      end
   end

endmodule
